// File: rtl/pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard
//   Tracks in-flight register writers in the stages after decode. It resolves
//   operand forwarding for the decode instruction and raises a stall when a
//   source depends on a result that is not yet forwardable.
//
// Parameters
//   AWL    register-address width
//   STAGES tracked stages after decode (1 = E, 2 = M, 3 = W ...), 2..7
//   ARDY   first stage from which a non-load result is forwardable
//   LDRDY  first stage from which a load result is forwardable
//   CW     stall-counter width
//
// Ports
//   CLK, RST_N         clock, asynchronous active-low reset
//   IssueV/WE/Ld/Rd    decode instruction: valid, writes RF, is load, dest
//   RsD, RtD           decode source registers
//   UseRs, UseRt       source is actually read
//   Flush              kill the decode instruction this cycle
//   Stall              hold fetch/decode (combinational)
//   FwdA, FwdB         operand source: 0 = RF, s = stage s result
//   Busy               bit s-1 set when stage s holds a valid writing entry
//   StallCnt           saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module pipe_scoreboard #(
   parameter int unsigned AWL    = 5,
   parameter int unsigned STAGES = 3,
   parameter int unsigned ARDY   = 1,
   parameter int unsigned LDRDY  = 2,
   parameter int unsigned CW     = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              IssueV,
   input  logic              IssueWE,
   input  logic              IssueLd,
   input  logic [AWL-1:0]    IssueRd,
   input  logic [AWL-1:0]    RsD,
   input  logic [AWL-1:0]    RtD,
   input  logic              UseRs,
   input  logic              UseRt,
   input  logic              Flush,
   output logic              Stall,
   output logic [2:0]        FwdA,
   output logic [2:0]        FwdB,
   output logic [STAGES-1:0] Busy,
   output logic [CW-1:0]     StallCnt
);

   // Index i holds stage i+1.
   logic [STAGES-1:0] r_valid;
   logic [STAGES-1:0] r_we;
   logic [STAGES-1:0] r_ld;
   logic [AWL-1:0]    r_rd [STAGES];
   logic [CW-1:0]     r_cnt;

   logic              w_haz_a;
   logic              w_haz_b;
   logic              w_issue;

   // Per-source resolution. Scanning from the youngest stage upward and
   // latching only the first hit gives youngest-match priority.
   always_comb begin
      logic        hit_a;
      logic        hit_b;
      logic        ld_a;
      logic        ld_b;
      int unsigned stg_a;
      int unsigned stg_b;
      logic        rdy_a;
      logic        rdy_b;

      hit_a = 1'b0;
      hit_b = 1'b0;
      ld_a  = 1'b0;
      ld_b  = 1'b0;
      stg_a = 0;
      stg_b = 0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         if (!hit_a && UseRs && (RsD != '0) && r_valid[i] && r_we[i] &&
             (r_rd[i] == RsD)) begin
            hit_a = 1'b1;
            ld_a  = r_ld[i];
            stg_a = i + 1;
         end
         if (!hit_b && UseRt && (RtD != '0) && r_valid[i] && r_we[i] &&
             (r_rd[i] == RtD)) begin
            hit_b = 1'b1;
            ld_b  = r_ld[i];
            stg_b = i + 1;
         end
      end

      rdy_a = ld_a ? (stg_a >= LDRDY) : (stg_a >= ARDY);
      rdy_b = ld_b ? (stg_b >= LDRDY) : (stg_b >= ARDY);

      w_haz_a = hit_a && !rdy_a;
      w_haz_b = hit_b && !rdy_b;
      FwdA    = (hit_a && rdy_a) ? 3'(stg_a) : 3'd0;
      FwdB    = (hit_b && rdy_b) ? 3'(stg_b) : 3'd0;
   end

   // Reset empties every stage, so no match can exist while RST_N is low:
   // Stall and Fwd are already zero then without extra gating.
   assign Stall   = (w_haz_a || w_haz_b) && IssueV && !Flush;
   assign w_issue = IssueV && !Stall && !Flush;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_valid <= '0;
         r_we    <= '0;
         r_ld    <= '0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            r_rd[i] <= '0;
         end
      end else begin
         r_valid[0] <= w_issue;
         r_we[0]    <= IssueWE;
         r_ld[0]    <= IssueLd;
         r_rd[0]    <= IssueRd;
         for (int unsigned i = 1; i < STAGES; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_we[i]    <= r_we[i-1];
            r_ld[i]    <= r_ld[i-1];
            r_rd[i]    <= r_rd[i-1];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt <= '0;
      end else if (Stall && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign Busy     = r_valid & r_we;
   assign StallCnt = r_cnt;

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       IssueV, IssueWE, IssueLd;
   logic [4:0] IssueRd, RsD, RtD;
   logic       UseRs, UseRt, Flush;
   logic       Stall;
   logic [2:0] FwdA, FwdB;
   logic [2:0] Busy;
   logic [3:0] StallCnt;

   int checks   = 0;
   int failures = 0;

   pipe_scoreboard #(
      .AWL(5), .STAGES(3), .ARDY(1), .LDRDY(2), .CW(4)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .IssueV(IssueV), .IssueWE(IssueWE), .IssueLd(IssueLd), .IssueRd(IssueRd),
      .RsD(RsD), .RtD(RtD), .UseRs(UseRs), .UseRt(UseRt), .Flush(Flush),
      .Stall(Stall), .FwdA(FwdA), .FwdB(FwdB), .Busy(Busy), .StallCnt(StallCnt)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input logic we, input logic ld,
                        input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt,
                        input logic fl);
      IssueV = v; IssueWE = we; IssueLd = ld; IssueRd = rd;
      RsD = rs; RtD = rt; UseRs = urs; UseRt = urt; Flush = fl;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      RST_N = 1'b1;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      drive(1, 1, 1, 5, 5, 5, 1, 1, 0);
      #3;
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", Stall); end
      checks++; if (FwdA !== 3'd0) begin failures++; $display("FAIL rst_fwda got=%0d exp=0", FwdA); end
      checks++; if (FwdB !== 3'd0) begin failures++; $display("FAIL rst_fwdb got=%0d exp=0", FwdB); end
      step();
      step();
      checks++; if (Busy !== 3'b000) begin failures++; $display("FAIL rst_busy got=%b exp=000", Busy); end
      checks++; if (StallCnt !== 4'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", StallCnt); end
      RST_N = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
   endtask

   task automatic test_forward_alu();
      do_reset();
      drive(1, 1, 0, 5, 0, 0, 0, 0, 0);
      #1;
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL alu_issue_stall got=%0b exp=0", Stall); end
      step();
      checks++; if (Busy !== 3'b001) begin failures++; $display("FAIL alu_busy1 got=%b exp=001", Busy); end
      drive(1, 0, 0, 0, 5, 0, 1, 0, 0);
      #1;
      checks++; if (FwdA !== 3'd1) begin failures++; $display("FAIL alu_fwd1 got=%0d exp=1", FwdA); end
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0b exp=0", Stall); end
      step();
      checks++; if (Busy !== 3'b010) begin failures++; $display("FAIL alu_busy2 got=%b exp=010", Busy); end
      checks++; if (FwdA !== 3'd2) begin failures++; $display("FAIL alu_fwd2 got=%0d exp=2", FwdA); end
      step();
      checks++; if (FwdA !== 3'd3) begin failures++; $display("FAIL alu_fwd3 got=%0d exp=3", FwdA); end
      drive(1, 0, 0, 0, 5, 0, 0, 0, 0);
      #1;
      checks++; if (FwdA !== 3'd0) begin failures++; $display("FAIL alu_unused got=%0d exp=0", FwdA); end
      step();
      checks++; if (FwdA !== 3'd0) begin failures++; $display("FAIL alu_retired got=%0d exp=0", FwdA); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 1, 1, 7, 0, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 7, 0, 1, 0);
      #1;
      checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL ld_stall got=%0b exp=1", Stall); end
      checks++; if (FwdB !== 3'd0) begin failures++; $display("FAIL ld_fwd0 got=%0d exp=0", FwdB); end
      step();
      checks++; if (StallCnt !== 4'd1) begin failures++; $display("FAIL ld_cnt got=%0d exp=1", StallCnt); end
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL ld_unstall got=%0b exp=0", Stall); end
      checks++; if (FwdB !== 3'd2) begin failures++; $display("FAIL ld_fwd2 got=%0d exp=2", FwdB); end
      checks++; if (Busy !== 3'b010) begin failures++; $display("FAIL ld_busy got=%b exp=010", Busy); end
      step();
      checks++; if (FwdB !== 3'd3) begin failures++; $display("FAIL ld_fwd3 got=%0d exp=3", FwdB); end
      checks++; if (StallCnt !== 4'd1) begin failures++; $display("FAIL ld_cnt_hold got=%0d exp=1", StallCnt); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
      step();
      #1;
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%0b exp=0", Stall); end
      step();
      drive(1, 0, 0, 0, 3, 3, 1, 0, 0);
      #1;
      checks++; if (FwdA !== 3'd1) begin failures++; $display("FAIL b2b_young got=%0d exp=1", FwdA); end
      checks++; if (FwdB !== 3'd0) begin failures++; $display("FAIL b2b_rt_unused got=%0d exp=0", FwdB); end
      checks++; if (Busy !== 3'b011) begin failures++; $display("FAIL b2b_busy got=%b exp=011", Busy); end
   endtask

   task automatic test_r0_and_flush();
      do_reset();
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
      #1;
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%0b exp=0", Stall); end
      checks++; if (FwdA !== 3'd0) begin failures++; $display("FAIL r0_fwda got=%0d exp=0", FwdA); end
      checks++; if (Busy !== 3'b001) begin failures++; $display("FAIL r0_busy got=%b exp=001", Busy); end
      step();
      drive(1, 1, 1, 9, 0, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 0, 9, 0, 1, 0, 1);
      #1;
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", Stall); end
      checks++; if (FwdA !== 3'd0) begin failures++; $display("FAIL flush_fwda got=%0d exp=0", FwdA); end
      step();
      checks++; if (Busy !== 3'b010) begin failures++; $display("FAIL flush_busy got=%b exp=010", Busy); end
      checks++; if (StallCnt !== 4'd0) begin failures++; $display("FAIL flush_cnt got=%0d exp=0", StallCnt); end
   endtask

   task automatic test_saturate_and_async_reset();
      do_reset();
      for (int n = 1; n <= 19; n++) begin
         drive(1, 1, 1, 9, 0, 0, 0, 0, 0);
         step();
         drive(1, 0, 0, 0, 9, 0, 1, 0, 0);
         step();
         if (n == 14) begin
            checks++; if (StallCnt !== 4'd14) begin failures++; $display("FAIL sat_14 got=%0d exp=14", StallCnt); end
         end
         if (n == 15) begin
            checks++; if (StallCnt !== 4'd15) begin failures++; $display("FAIL sat_15 got=%0d exp=15", StallCnt); end
         end
      end
      checks++; if (StallCnt !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", StallCnt); end
      drive(1, 1, 1, 9, 0, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 0, 9, 0, 1, 0, 0);
      #1;
      checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL mid_stall got=%0b exp=1", Stall); end
      RST_N = 1'b0;
      #1;
      checks++; if (Busy !== 3'b000) begin failures++; $display("FAIL async_busy got=%b exp=000", Busy); end
      checks++; if (StallCnt !== 4'd0) begin failures++; $display("FAIL async_cnt got=%0d exp=0", StallCnt); end
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL async_stall got=%0b exp=0", Stall); end
      step();
      RST_N = 1'b1;
      #1;
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL post_rst_stall got=%0b exp=0", Stall); end
      checks++; if (FwdA !== 3'd0) begin failures++; $display("FAIL post_rst_fwda got=%0d exp=0", FwdA); end
      step();
      checks++; if (Busy !== 3'b000) begin failures++; $display("FAIL post_rst_busy got=%b exp=000", Busy); end
      checks++; if (StallCnt !== 4'd0) begin failures++; $display("FAIL post_rst_cnt got=%0d exp=0", StallCnt); end
   endtask

   initial begin
      RST_N = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_forward_alu();
      test_load_use();
      test_back_to_back();
      test_r0_and_flush();
      test_saturate_and_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 Parameter AWL, default 5, register-address width.
REQ-002 Parameter STAGES, default 3, tracked stages after decode (stage 1 = E, 2 = M, 3 = W); legal range 2..7.
REQ-003 Parameter ARDY, default 1, first stage from which a non-load result is forwardable.
REQ-004 Parameter LDRDY, default 2, first stage from which a load result is forwardable; ARDY <= LDRDY <= STAGES.
REQ-005 Parameter CW, default 16, stall-counter width.
REQ-006 CLK  input  1  single clock; all state changes on rising edge.
REQ-007 RST_N  input  1  asynchronous, active-low reset.
REQ-008 IssueV  input  1  decode holds a valid instruction.
REQ-009 IssueWE  input  1  decode instruction writes the register file.
REQ-010 IssueLd  input  1  decode instruction is a load.
REQ-011 IssueRd  input  AWL  decode destination register.
REQ-012 RsD, RtD  input  AWL each  decode source registers.
REQ-013 UseRs, UseRt  input  1 each  corresponding source is actually read.
REQ-014 Flush  input  1  kill the decode instruction this cycle.
REQ-015 Stall  output  1  hold fetch/decode this cycle.
REQ-016 FwdA, FwdB  output  3  operand source: 0 = register file, s = stage s result.
REQ-017 Busy  output  STAGES  bit s-1 = stage s holds a valid writing entry.
REQ-018 StallCnt  output  CW  count of stall cycles since reset.

Function
REQ-019 Each stage s holds an entry {valid, we, ld, rd}; every cycle entry s <= entry s-1 for s >= 2.
REQ-020 Stage 1 loads {1, IssueWE, IssueLd, IssueRd} when IssueV && !Stall && !Flush, otherwise a bubble (valid = 0).
REQ-021 Entry in stage STAGES retires on the next edge; the register file is write-before-read, so a retired entry needs no forwarding.
REQ-022 Per source (Rs with UseRs, Rt with UseRt): match = valid && we && rd == source && source != 0.
REQ-023 Youngest match (lowest s) wins; older matches are ignored.
REQ-024 No match or unused source -> Fwd = 0.
REQ-025 Winning match non-load with s >= ARDY, or load with s >= LDRDY -> Fwd = s, no hazard.
REQ-026 Winning match below its ready stage -> hazard; Fwd = 0 that cycle.
REQ-027 Stall = (hazard on Rs || hazard on Rt) && IssueV && !Flush; purely combinational from inputs and stage state.
REQ-028 Flush and hazard in the same cycle: Stall = 0, bubble enters stage 1, Flush wins.
REQ-029 Stalled cycle inserts a bubble into stage 1; the decode instruction re-evaluates next cycle against advanced state.
REQ-030 StallCnt increments by 1 on each edge where Stall = 1; saturates at 2^CW-1, no wrap.
REQ-031 Busy reflects registered stage state only (valid && we).

Reset
REQ-032 RST_N low asynchronously clears all entries to invalid, Busy = 0, StallCnt = 0.
REQ-033 During reset Stall = 0 and FwdA = FwdB = 0 regardless of inputs.
REQ-034 Reset asserted mid-stall discards all in-flight entries; the first cycle after release sees an empty pipe.
REQ-035 Reset release is synchronised externally; first valid edge after RST_N high follows REQ-020.

Verification (defaults STAGES=3, ARDY=1, LDRDY=2)
REQ-036 Issue add r5 (we), next cycle decode reads Rs=r5 -> Stall=0, FwdA=1; following cycle FwdA=2 if still read.
REQ-037 Issue load r7, next cycle decode reads Rt=r7 -> Stall=1 for exactly one cycle, FwdB=0, StallCnt=1; next cycle FwdB=2, Stall=0.
REQ-038 Issue add r3, add r3 back-to-back, then read r3 -> FwdA=1 (youngest), not 2.
REQ-039 Load r0, then read r0 -> Stall=0, FwdA=0; load r9 with Flush=1 in the hazard cycle -> Stall=0, Busy bit0=0 next cycle.
REQ-040 Force hazard 2^CW+3 consecutive cycles (CW=4 override) -> StallCnt holds at 15; pulse RST_N low mid-run -> Busy=0, StallCnt=0 immediately, no clock needed.
